ps2_cmd_sched: RTL and testbench
================================

PS2_CMD_SCHED -- requirements
Module: ps2_cmd_sched

Interface
REQ-001 Parameter ACK_TMO, default 48000, sets the ACK wait limit in clk cycles (1 ms at 48 MHz).
REQ-002 Parameter BAT_TMO, default 24'd9600000, sets the BAT wait limit after a reset command (200 ms).
REQ-003 Parameter MAX_RETRY, default 3, sets the resend attempts per byte after FE or timeout.
REQ-004 Port clk, input, 1 bit: system clock.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 Port led_req, input, 1 bit: pulse requesting an LED update.
REQ-007 Port led_val, input, 3 bits: {caps, num, scroll}, sampled on led_req.
REQ-008 Port rate_req, input, 1 bit: pulse requesting a typematic update.
REQ-009 Port rate_val, input, 8 bits: typematic byte, sampled on rate_req.
REQ-010 Port kbd_rst_req, input, 1 bit: pulse requesting a keyboard reset.
REQ-011 Port tx_write, output, 1 bit: one-cycle pulse starting a host-to-device byte.
REQ-012 Port tx_data, output, 8 bits: byte to send, held stable from tx_write until tx_done or tx_err.
REQ-013 Port tx_done, input, 1 bit: pulse meaning the byte was sent and line-ACKed.
REQ-014 Port tx_err, input, 1 bit: pulse meaning the line-level ACK failed.
REQ-015 Port rx_valid, input, 1 bit: pulse meaning a device byte was received.
REQ-016 Port rx_data, input, 8 bits: received byte.
REQ-017 Port key_valid, output, 1 bit: rx_valid forwarded when the byte is not consumed.
REQ-018 Port key_data, output, 8 bits: forwarded byte.
REQ-019 Port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-020 Port cmd_done, output, 1 bit: one-cycle pulse on successful completion of a sequence.
REQ-021 Port cmd_fail, output, 1 bit: one-cycle pulse on an aborted sequence.
REQ-022 Port fail_code, output, 2 bits: 1 = retry exhausted, 2 = BAT timeout, 3 = BAT error (FC); held until the next sequence starts.

Function
REQ-023 Each request pulse shall set a sticky pending flag and capture its value; a later request of the same type before service shall overwrite the value and keep one pending flag.
REQ-024 Arbitration in IDLE shall use fixed priority kbd_rst > led > rate, and the winner's pending flag shall clear when its sequence starts.
REQ-025 The states shall be IDLE, SEND, WAIT_TX, WAIT_ACK, WAIT_BAT, FINISH.
REQ-026 Sequences: LED = ED then {5'b0, led_val}; rate = F3 then {1'b0, rate_val[6:0]}; reset = FF then wait for BAT.
REQ-027 SEND shall assert tx_write for exactly one cycle and then go to WAIT_TX.
REQ-028 In WAIT_TX, tx_done shall go to WAIT_ACK and start the ACK timer; tx_err shall count as a retry.
REQ-029 In WAIT_ACK, rx FA shall advance to the next byte, to WAIT_BAT (reset command), or to FINISH.
REQ-030 In WAIT_ACK, rx FE or an ACK_TMO expiry shall resend the same byte; any other byte shall be consumed and ignored.
REQ-031 The retry counter shall reset per byte; the attempt after MAX_RETRY resends shall abort with cmd_fail, fail_code 1, and return to IDLE.
REQ-032 In WAIT_BAT, AA shall go to FINISH; FC shall fail with code 3; a BAT_TMO expiry shall fail with code 2.
REQ-033 FINISH shall pulse cmd_done and return to IDLE one cycle later; a new sequence shall not start earlier than the cycle after FINISH.
REQ-034 In WAIT_ACK and WAIT_BAT, every rx byte shall be consumed and key_valid suppressed; in all other states key_valid/key_data shall equal rx_valid/rx_data combinationally delayed by one register (latency 1).
REQ-035 A request arriving in the same cycle as FINISH or cmd_fail shall be latched and served from the next IDLE.
REQ-036 rx_valid coinciding with a timeout expiry shall take precedence over the timeout.
REQ-037 Timer counters shall saturate-compare on equality and reload to 0 on every state entry.

Reset
REQ-038 On rst_n low, the block shall go to IDLE and clear all pending flags, counters, and timers.
REQ-039 Reset values: tx_write 0, tx_data 00, key_valid 0, key_data 00, busy 0, cmd_done 0, cmd_fail 0, fail_code 0.
REQ-040 Reset mid-sequence shall abandon the sequence without issuing any pulse.

Structure
REQ-041 A shared package ps2_pkg shall hold command constants ED, F3, FF, FA, FE, AA, FC, the state encoding, and the fail codes.
REQ-042 One sub-module, ps2_tmo_timer (enable/clear, terminal-count pulse, width from parameter), shall serve both timeouts.

Verification
REQ-043 Bench scenario: led_req with led_val=3'b100, tx_done, then rx FA twice -> tx bytes ED, 04; cmd_done once; no key_valid.
REQ-044 Bench scenario: rate_req and led_req in the same cycle -> LED sequence completes first, then F3 and the rate byte are sent.
REQ-045 Bench scenario: rx FE after ED three times, then FA -> ED sent 4 times, the sequence succeeds; with a 4th FE -> cmd_fail, fail_code 1.
REQ-046 Bench scenario: kbd_rst_req, FA, then no AA for BAT_TMO -> cmd_fail, fail_code 2; repeat with AA -> cmd_done.
REQ-047 Bench scenario: rx 1C in IDLE -> key_valid with key_data 1C one cycle later; rx 1C during WAIT_ACK -> suppressed.
REQ-048 Bench scenario: rst_n asserted in WAIT_ACK -> all outputs at reset values immediately; no cmd_done or cmd_fail afterwards.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 command constants, scheduler state encoding and fail codes.
package ps2_pkg;

   localparam logic [7:0] CMD_ED = 8'hED;
   localparam logic [7:0] CMD_F3 = 8'hF3;
   localparam logic [7:0] CMD_FF = 8'hFF;
   localparam logic [7:0] RSP_FA = 8'hFA;
   localparam logic [7:0] RSP_FE = 8'hFE;
   localparam logic [7:0] RSP_AA = 8'hAA;
   localparam logic [7:0] RSP_FC = 8'hFC;

   localparam int unsigned ST_W = 3;
   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_SEND     = 3'd1;
   localparam logic [2:0] ST_WAIT_TX  = 3'd2;
   localparam logic [2:0] ST_WAIT_ACK = 3'd3;
   localparam logic [2:0] ST_WAIT_BAT = 3'd4;
   localparam logic [2:0] ST_FINISH   = 3'd5;

   localparam logic [1:0] FAIL_NONE    = 2'd0;
   localparam logic [1:0] FAIL_RETRY   = 2'd1;
   localparam logic [1:0] FAIL_BAT_TMO = 2'd2;
   localparam logic [1:0] FAIL_BAT_ERR = 2'd3;

   // Description of one host-to-device command sequence.
   typedef struct packed {
      logic [7:0] cmd;
      logic [7:0] arg;
      logic       two_byte;
      logic       wait_bat;
   } seq_t;

   function automatic seq_t led_seq(input logic [2:0] v);
      seq_t s;
      s.cmd      = CMD_ED;
      s.arg      = {5'b0, v};
      s.two_byte = 1'b1;
      s.wait_bat = 1'b0;
      return s;
   endfunction

   function automatic seq_t rate_seq(input logic [7:0] v);
      seq_t s;
      s.cmd      = CMD_F3;
      s.arg      = v & 8'h7F;
      s.two_byte = 1'b1;
      s.wait_bat = 1'b0;
      return s;
   endfunction

   function automatic seq_t rst_seq();
      seq_t s;
      s.cmd      = CMD_FF;
      s.arg      = 8'h00;
      s.two_byte = 1'b0;
      s.wait_bat = 1'b1;
      return s;
   endfunction

endpackage

// File: rtl/ps2_tmo_timer.sv
// Saturating timeout counter: counts while enabled, one-cycle pulse on reaching limit.
module ps2_tmo_timer #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] limit,
   output logic             tc_c
);

   logic [WIDTH-1:0] cnt_q;
   logic             hit_q;

   assign tc_c = en & ~hit_q & (cnt_q == limit);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         hit_q <= 1'b0;
      end else if (clr) begin
         cnt_q <= '0;
         hit_q <= 1'b0;
      end else if (en) begin
         if (cnt_q != limit) cnt_q <= cnt_q + WIDTH'(1);
         if (tc_c) hit_q <= 1'b1;
      end
   end

endmodule

// File: rtl/ps2_cmd_sched.sv
// PS/2 host command scheduler: arbitrates LED/typematic/reset requests and
// runs each command sequence with ACK, resend and BAT handling.
module ps2_cmd_sched
   import ps2_pkg::*;
#(
   parameter int unsigned ACK_TMO   = 48000,
   parameter int unsigned BAT_TMO   = 24'd9600000,
   parameter int unsigned MAX_RETRY = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       led_req,
   input  logic [2:0] led_val,
   input  logic       rate_req,
   input  logic [7:0] rate_val,
   input  logic       kbd_rst_req,
   output logic       tx_write,
   output logic [7:0] tx_data,
   input  logic       tx_done,
   input  logic       tx_err,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   output logic       key_valid,
   output logic [7:0] key_data,
   output logic       busy,
   output logic       cmd_done,
   output logic       cmd_fail,
   output logic [1:0] fail_code
);

   localparam int unsigned TMR_MAX = (ACK_TMO > BAT_TMO) ? ACK_TMO : BAT_TMO;
   localparam int unsigned TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX + 1);
   localparam int unsigned RTY_W   = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

   logic [ST_W-1:0]  state_q, state_d;
   seq_t             seq_q, seq_d;
   logic             byte_idx_q, byte_idx_d;
   logic [RTY_W-1:0] retry_q, retry_d;
   logic [7:0]       tx_data_d;
   logic [1:0]       fail_code_d;
   logic             cmd_fail_d;

   logic             led_pend_q, rate_pend_q, rst_pend_q;
   logic [2:0]       led_val_q;
   logic [7:0]       rate_val_q;
   logic             led_take_c, rate_take_c, rst_take_c;
   logic             start_c, retry_c;

   logic             tmr_en_c, tmr_clr_c, tmo_c;
   logic [TMR_W-1:0] tmr_limit_c;
   logic             rx_consume_c;

   assign rx_consume_c = (state_q == ST_WAIT_ACK) | (state_q == ST_WAIT_BAT);
   assign tmr_en_c     = rx_consume_c;
   assign tmr_clr_c    = (state_d != state_q);
   assign tmr_limit_c  = (state_q == ST_WAIT_BAT) ? TMR_W'(BAT_TMO) : TMR_W'(ACK_TMO);

   ps2_tmo_timer #(.WIDTH(TMR_W)) u_tmr (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (tmr_en_c),
      .clr   (tmr_clr_c),
      .limit (tmr_limit_c),
      .tc_c  (tmo_c)
   );

   // Next-state and sequence bookkeeping.
   always_comb begin
      state_d     = state_q;
      seq_d       = seq_q;
      byte_idx_d  = byte_idx_q;
      retry_d     = retry_q;
      tx_data_d   = tx_data;
      fail_code_d = fail_code;
      cmd_fail_d  = 1'b0;
      led_take_c  = 1'b0;
      rate_take_c = 1'b0;
      rst_take_c  = 1'b0;
      start_c     = 1'b0;
      retry_c     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (rst_pend_q) begin
               rst_take_c = 1'b1;
               seq_d      = rst_seq();
               start_c    = 1'b1;
            end else if (led_pend_q) begin
               led_take_c = 1'b1;
               seq_d      = led_seq(led_val_q);
               start_c    = 1'b1;
            end else if (rate_pend_q) begin
               rate_take_c = 1'b1;
               seq_d       = rate_seq(rate_val_q);
               start_c     = 1'b1;
            end
            if (start_c) begin
               byte_idx_d  = 1'b0;
               retry_d     = '0;
               fail_code_d = FAIL_NONE;
               tx_data_d   = seq_d.cmd;
               state_d     = ST_SEND;
            end
         end
         ST_SEND: state_d = ST_WAIT_TX;
         ST_WAIT_TX: begin
            if (tx_done)     state_d = ST_WAIT_ACK;
            else if (tx_err) retry_c = 1'b1;
         end
         ST_WAIT_ACK: begin
            // A received byte always wins over a coincident timeout.
            if (rx_valid) begin
               if (rx_data == RSP_FA) begin
                  if (seq_q.wait_bat) begin
                     state_d = ST_WAIT_BAT;
                  end else if (seq_q.two_byte && !byte_idx_q) begin
                     byte_idx_d = 1'b1;
                     retry_d    = '0;
                     tx_data_d  = seq_q.arg;
                     state_d    = ST_SEND;
                  end else begin
                     state_d = ST_FINISH;
                  end
               end else if (rx_data == RSP_FE) begin
                  retry_c = 1'b1;
               end
            end else if (tmo_c) begin
               retry_c = 1'b1;
            end
         end
         ST_WAIT_BAT: begin
            if (rx_valid) begin
               if (rx_data == RSP_AA) begin
                  state_d = ST_FINISH;
               end else if (rx_data == RSP_FC) begin
                  state_d     = ST_IDLE;
                  cmd_fail_d  = 1'b1;
                  fail_code_d = FAIL_BAT_ERR;
               end
            end else if (tmo_c) begin
               state_d     = ST_IDLE;
               cmd_fail_d  = 1'b1;
               fail_code_d = FAIL_BAT_TMO;
            end
         end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase

      if (retry_c) begin
         if (retry_q == RTY_W'(MAX_RETRY)) begin
            state_d     = ST_IDLE;
            cmd_fail_d  = 1'b1;
            fail_code_d = FAIL_RETRY;
         end else begin
            retry_d = retry_q + RTY_W'(1);
            state_d = ST_SEND;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         seq_q       <= '0;
         byte_idx_q  <= 1'b0;
         retry_q     <= '0;
         tx_write    <= 1'b0;
         tx_data     <= 8'h00;
         key_valid   <= 1'b0;
         key_data    <= 8'h00;
         busy        <= 1'b0;
         cmd_done    <= 1'b0;
         cmd_fail    <= 1'b0;
         fail_code   <= FAIL_NONE;
         led_pend_q  <= 1'b0;
         rate_pend_q <= 1'b0;
         rst_pend_q  <= 1'b0;
         led_val_q   <= 3'b000;
         rate_val_q  <= 8'h00;
      end else begin
         state_q    <= state_d;
         seq_q      <= seq_d;
         byte_idx_q <= byte_idx_d;
         retry_q    <= retry_d;
         tx_write   <= (state_d == ST_SEND);
         tx_data    <= tx_data_d;
         busy       <= (state_d != ST_IDLE);
         cmd_done   <= (state_d == ST_FINISH);
         cmd_fail   <= cmd_fail_d;
         fail_code  <= fail_code_d;
         key_valid  <= rx_valid & ~rx_consume_c;
         if (rx_valid && !rx_consume_c) key_data <= rx_data;
         // A new request in the service cycle stays pending with its new value.
         led_pend_q  <= led_req | (led_pend_q & ~led_take_c);
         rate_pend_q <= rate_req | (rate_pend_q & ~rate_take_c);
         rst_pend_q  <= kbd_rst_req | (rst_pend_q & ~rst_take_c);
         if (led_req)  led_val_q  <= led_val;
         if (rate_req) rate_val_q <= rate_val;
      end
   end

endmodule

// File: tb/tb_ps2_cmd_sched.sv
// Scoreboard bench for ps2_cmd_sched: a behavioural model plans each sequence's
// device reactions and expected events; a monitor pops and compares.
module tb_ps2_cmd_sched;

   localparam int ACK_TMO   = 20;
   localparam int BAT_TMO   = 60;
   localparam int MAX_RETRY = 3;

   localparam int EV_TX = 0, EV_KEY = 1, EV_DONE = 2, EV_FAIL = 3;
   localparam int R_FA = 0, R_FE = 1, R_TXERR = 2, R_TMO = 3, R_JUNK = 4;
   localparam int B_AA = 10, B_FC = 11, B_TMO = 12, B_JUNK = 13;
   localparam int K_LED = 0, K_RATE = 1, K_RST = 2;

   typedef struct packed {
      logic [3:0] kind;
      logic [7:0] data;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       led_req = 1'b0, rate_req = 1'b0, kbd_rst_req = 1'b0;
   logic [2:0] led_val = 3'b000;
   logic [7:0] rate_val = 8'h00;
   logic       tx_done = 1'b0, tx_err = 1'b0, rx_valid = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       tx_write, key_valid, busy, cmd_done, cmd_fail;
   logic [7:0] tx_data, key_data;
   logic [1:0] fail_code;

   int   vectors = 0;
   int   miscompares = 0;
   ev_t  exp_q[$];
   int   react_q[$];
   int   force_q[$];

   always #5 clk = ~clk;

   ps2_cmd_sched #(.ACK_TMO(ACK_TMO), .BAT_TMO(BAT_TMO), .MAX_RETRY(MAX_RETRY)) dut (
      .clk(clk), .rst_n(rst_n),
      .led_req(led_req), .led_val(led_val),
      .rate_req(rate_req), .rate_val(rate_val),
      .kbd_rst_req(kbd_rst_req),
      .tx_write(tx_write), .tx_data(tx_data),
      .tx_done(tx_done), .tx_err(tx_err),
      .rx_valid(rx_valid), .rx_data(rx_data),
      .key_valid(key_valid), .key_data(key_data),
      .busy(busy), .cmd_done(cmd_done), .cmd_fail(cmd_fail), .fail_code(fail_code)
   );

   function automatic ev_t mk(input int k, input logic [7:0] d);
      ev_t e;
      e.kind = 4'(k);
      e.data = d;
      return e;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %02h, expected %02h", name, act, req);
      end
   endtask

   function automatic int next_react();
      int x;
      if (force_q.size() > 0) return force_q.pop_front();
      x = int'($urandom_range(0, 99));
      if (x < 60) return R_FA;
      if (x < 72) return R_FE;
      if (x < 80) return R_TXERR;
      if (x < 88) return R_JUNK;
      return R_TMO;
   endfunction

   function automatic int next_bat();
      int x;
      if (force_q.size() > 0) return force_q.pop_front();
      x = int'($urandom_range(0, 99));
      if (x < 55) return B_AA;
      if (x < 70) return B_JUNK;
      if (x < 85) return B_FC;
      return B_TMO;
   endfunction

   // Reference model: expected event stream and device reaction plan per request.
   task automatic plan_txn(input int kind, input logic [7:0] v);
      logic [7:0] bytes [2];
      int nb, fails, r, b;
      bit ok, acked;
      nb = 2;
      case (kind)
         K_LED:   begin bytes[0] = 8'hED; bytes[1] = {5'b0, v[2:0]}; end
         K_RATE:  begin bytes[0] = 8'hF3; bytes[1] = v & 8'h7F; end
         default: begin bytes[0] = 8'hFF; bytes[1] = 8'h00; nb = 1; end
      endcase
      ok = 1'b1;
      for (int i = 0; i < nb && ok; i++) begin
         fails = 0;
         acked = 1'b0;
         while (!acked && ok) begin
            exp_q.push_back(mk(EV_TX, bytes[i]));
            r = next_react();
            react_q.push_back(r);
            if (r == R_FA || r == R_JUNK) acked = 1'b1;
            else begin
               fails++;
               if (fails > MAX_RETRY) begin
                  exp_q.push_back(mk(EV_FAIL, 8'd1));
                  ok = 1'b0;
               end
            end
         end
      end
      if (ok) begin
         if (kind == K_RST) begin
            b = next_bat();
            react_q.push_back(b);
            if (b == B_FC)       exp_q.push_back(mk(EV_FAIL, 8'd3));
            else if (b == B_TMO) exp_q.push_back(mk(EV_FAIL, 8'd2));
            else                 exp_q.push_back(mk(EV_DONE, 8'd0));
         end else begin
            exp_q.push_back(mk(EV_DONE, 8'd0));
         end
      end
   endtask

   task automatic send_rx(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   // Keyboard model: plays the planned reaction for every byte the DUT writes.
   task automatic responder();
      int r, b;
      logic [7:0] sent;
      forever begin
         @(negedge clk);
         if (rst_n && tx_write) begin
            sent = tx_data;
            r = (react_q.size() > 0) ? react_q.pop_front() : R_TMO;
            repeat (3) @(posedge clk);
            #1;
            if (r == R_TXERR) begin
               tx_err = 1'b1; @(posedge clk); #1; tx_err = 1'b0;
            end else begin
               tx_done = 1'b1; @(posedge clk); #1; tx_done = 1'b0;
               repeat (2) @(posedge clk);
               #1;
               if (r == R_FE) send_rx(8'hFE);
               else if (r == R_FA || r == R_JUNK) begin
                  if (r == R_JUNK) begin
                     send_rx(8'h1C);
                     repeat (2) @(posedge clk);
                     #1;
                  end
                  send_rx(8'hFA);
                  if (sent == 8'hFF) begin
                     b = (react_q.size() > 0) ? react_q.pop_front() : B_TMO;
                     repeat (4) @(posedge clk);
                     #1;
                     if (b == B_AA) send_rx(8'hAA);
                     else if (b == B_FC) send_rx(8'hFC);
                     else if (b == B_JUNK) begin
                        send_rx(8'h1C);
                        repeat (2) @(posedge clk);
                        #1;
                        send_rx(8'hAA);
                     end
                  end
               end
            end
         end
      end
   endtask

   task automatic chk_ev(input int k, input logic [7:0] d);
      ev_t e;
      vectors++;
      if (exp_q.size() == 0) begin
         miscompares++;
         $display("FAIL event: got kind %0d data %02h, expected none", k, d);
      end else begin
         e = exp_q.pop_front();
         if (int'(e.kind) != k || e.data !== d) begin
            miscompares++;
            $display("FAIL event: got kind %0d data %02h, expected kind %0d data %02h",
                     k, d, e.kind, e.data);
         end
      end
   endtask

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (tx_write)  chk_ev(EV_TX, tx_data);
            if (key_valid) chk_ev(EV_KEY, key_data);
            if (cmd_done)  chk_ev(EV_DONE, 8'd0);
            if (cmd_fail)  chk_ev(EV_FAIL, {6'b0, fail_code});
         end
      end
   end

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 3000) begin
         vectors++;
         miscompares++;
         $display("FAIL drain: timed out with %0d events outstanding, expected 0", exp_q.size());
         exp_q.delete();
         react_q.delete();
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic pulse_req(input bit l, input bit r, input bit k,
                            input logic [2:0] lv, input logic [7:0] rv);
      led_req = l; rate_req = r; kbd_rst_req = k;
      if (l) led_val = lv;
      if (r) rate_val = rv;
      @(posedge clk); #1;
      led_req = 1'b0; rate_req = 1'b0; kbd_rst_req = 1'b0;
   endtask

   task automatic idle_key(input logic [7:0] b);
      exp_q.push_back(mk(EV_KEY, b));
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      chk("key_latency_valid", {7'b0, key_valid}, 8'd1);
      chk("key_latency_data", key_data, b);
      @(posedge clk); #1;
      chk("key_pulse_end", {7'b0, key_valid}, 8'd0);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_tx_write", {7'b0, tx_write}, 8'd0);
      chk("rst_tx_data", tx_data, 8'h00);
      chk("rst_key_valid", {7'b0, key_valid}, 8'd0);
      chk("rst_key_data", key_data, 8'h00);
      chk("rst_busy", {7'b0, busy}, 8'd0);
      chk("rst_cmd_done", {7'b0, cmd_done}, 8'd0);
      chk("rst_cmd_fail", {7'b0, cmd_fail}, 8'd0);
      chk("rst_fail_code", {6'b0, fail_code}, 8'd0);
   endtask

   initial begin : main
      logic [7:0] v;
      int k, n;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs();
      rst_n = 1'b1;
      fork
         responder();
      join_none
      @(posedge clk); #1;

      // LED 3'b100 acknowledged cleanly.
      force_q = '{R_FA, R_FA};
      plan_txn(K_LED, 8'h04);
      pulse_req(1, 0, 0, 3'b100, 8'h00);
      drain();

      // Simultaneous rate and LED requests: LED first.
      force_q = '{R_FA, R_FA, R_FA, R_FA};
      plan_txn(K_LED, 8'h03);
      plan_txn(K_RATE, 8'hB5);
      pulse_req(1, 1, 0, 3'b011, 8'hB5);
      drain();

      // Three resends then success; four resends then abort.
      force_q = '{R_FE, R_FE, R_FE, R_FA, R_FA};
      plan_txn(K_LED, 8'h01);
      pulse_req(1, 0, 0, 3'b001, 8'h00);
      drain();
      force_q = '{R_FE, R_FE, R_FE, R_FE};
      plan_txn(K_LED, 8'h02);
      pulse_req(1, 0, 0, 3'b010, 8'h00);
      drain();
      chk("fail_code_hold", {6'b0, fail_code}, 8'd1);

      // Keyboard reset: BAT timeout, BAT pass, BAT error.
      force_q = '{R_FA, B_TMO};
      plan_txn(K_RST, 8'h00);
      pulse_req(0, 0, 1, 3'b000, 8'h00);
      drain();
      force_q = '{R_FA, B_AA};
      plan_txn(K_RST, 8'h00);
      pulse_req(0, 0, 1, 3'b000, 8'h00);
      drain();
      chk("fail_code_cleared", {6'b0, fail_code}, 8'd0);
      force_q = '{R_FA, B_FC};
      plan_txn(K_RST, 8'h00);
      pulse_req(0, 0, 1, 3'b000, 8'h00);
      drain();

      // Pass-through in IDLE, suppression during WAIT_ACK.
      idle_key(8'h1C);
      force_q = '{R_JUNK, R_FA};
      plan_txn(K_LED, 8'h05);
      pulse_req(1, 0, 0, 3'b101, 8'h00);
      drain();

      // tx_err and ACK timeout count as retries.
      force_q = '{R_TXERR, R_TMO, R_FA, R_FA};
      plan_txn(K_RATE, 8'h2A);
      pulse_req(0, 1, 0, 3'b000, 8'h2A);
      drain();

      // Two LED requests while busy: only the later value is sent.
      force_q = '{R_FA, R_FA, R_FA, R_FA};
      plan_txn(K_RATE, 8'h7F);
      plan_txn(K_LED, 8'h06);
      pulse_req(0, 1, 0, 3'b000, 8'h7F);
      repeat (3) @(posedge clk);
      #1;
      pulse_req(1, 0, 0, 3'b001, 8'h00);
      pulse_req(1, 0, 0, 3'b110, 8'h00);
      drain();

      // Randomized sequences with random device behaviour.
      for (int t = 0; t < 30; t++) begin
         if ($urandom_range(0, 4) == 0) idle_key(8'($urandom));
         k = int'($urandom_range(0, 2));
         v = 8'($urandom);
         plan_txn(k, v);
         pulse_req(k == K_LED, k == K_RATE, k == K_RST, v[2:0], v);
         drain();
      end

      // Reset while waiting for ACK abandons the sequence silently.
      exp_q.push_back(mk(EV_TX, 8'hED));
      react_q.push_back(R_TMO);
      pulse_req(1, 0, 0, 3'b111, 8'h00);
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("rst_seq_started", 8'(exp_q.size()), 8'd0);
      repeat (8) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs();
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (60) @(posedge clk);
      #1;
      chk("post_reset_busy", {7'b0, busy}, 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule
